// File: rtl/mips_pkg.sv
// Shared MIPS core types and architectural constants: register indices,
// word/index typedefs and register-file reset values.
package mips_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_FP   = 5'd30;
  localparam reg_idx_t REG_RA   = 5'd31;

  localparam word_t DEF_SP_INIT = 32'h8012_0000;
  localparam word_t DEF_RA_INIT = 32'h0000_0000;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bus: one write port from write-back, two read ports to decode.
// Master drives indices/write data; slave returns combinational read data.
interface reg_file_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);

  logic [AW-1:0]    wr_num;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic [AW-1:0]    rd0_num;
  logic [WIDTH-1:0] rd0_data;
  logic [AW-1:0]    rd1_num;
  logic [WIDTH-1:0] rd1_data;

  modport master (
    output wr_num, wr_data, wr_en, rd0_num, rd1_num,
    input  rd0_data, rd1_data
  );

  modport slave (
    input  wr_num, wr_data, wr_en, rd0_num, rd1_num,
    output rd0_data, rd1_data
  );

endinterface

// File: rtl/reg_file_rdport.sv
// Read mux for one register-file port with R0 forced to zero.
// Latency: combinational; backpressure: none.
module reg_file_rdport #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [WIDTH-1:0] regs [NREGS],
  input  logic [AW-1:0]    num,
  output logic [WIDTH-1:0] data
);

  always_comb begin
    data = '0;
    if (num != '0) begin
      data = regs[num];
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS register file: two combinational read ports, one synchronous write port.
// Latency: write 1 clock, read 0 (no write-to-read bypass); backpressure: none.
module reg_file
  import mips_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               NREGS   = 32,
  parameter logic [WIDTH-1:0] SP_INIT = DEF_SP_INIT,
  parameter logic [WIDTH-1:0] RA_INIT = DEF_RA_INIT
) (
  input logic         clk,
  input logic         reset,
  reg_file_if.slave   bus
);

  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && (bus.wr_num != AW'(REG_ZERO))) begin
      regs_d[bus.wr_num] = bus.wr_data;
    end
  end

  // Reset wins over a concurrent write; sp and ra get architectural start values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == int'(REG_SP)) begin
          regs_q[i] <= SP_INIT;
        end else if (i == int'(REG_RA)) begin
          regs_q[i] <= RA_INIT;
        end else begin
          regs_q[i] <= '0;
        end
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_file_rdport #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rdport0 (
    .regs (regs_q),
    .num  (bus.rd0_num),
    .data (bus.rd0_data)
  );

  reg_file_rdport #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rdport1 (
    .regs (regs_q),
    .num  (bus.rd1_num),
    .data (bus.rd1_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: reset values, write/read timing, R0 protection,
// dual-port reads, write-disable and mid-operation reset.
module tb_reg_file;

  localparam logic [31:0] SP_VAL = 32'h8012_0000;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  reg_file_if #(.WIDTH(32), .AW(5)) bus ();

  reg_file #(
    .WIDTH   (32),
    .NREGS   (32),
    .SP_INIT (SP_VAL),
    .RA_INIT (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] num, input logic [31:0] dat);
    bus.wr_en   = en;
    bus.wr_num  = num;
    bus.wr_data = dat;
  endtask

  task automatic set_rd(input logic [4:0] n0, input logic [4:0] n1);
    bus.rd0_num = n0;
    bus.rd1_num = n1;
    #1;
  endtask

  initial begin
    logic [31:0] exp_v;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    bus.rd0_num = '0;
    bus.rd1_num = '0;

    // Reset held two cycles, then sweep every index on both ports.
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      exp_v = (i == 29) ? SP_VAL : 32'h0;
      chk($sformatf("reset_rd0_r%0d", i), bus.rd0_data, exp_v);
      exp_v = ((31 - i) == 29) ? SP_VAL : 32'h0;
      chk($sformatf("reset_rd1_r%0d", 31 - i), bus.rd1_data, exp_v);
    end

    // Write R5: old value before the edge, new value after.
    set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    set_rd(5'd5, 5'd5);
    chk("r5_before_edge", bus.rd0_data, 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("r5_after_edge", bus.rd0_data, 32'hDEAD_BEEF);
    chk("r5_rd1_same", bus.rd1_data, 32'hDEAD_BEEF);

    // R0 ignores writes.
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd0, 5'd0);
    chk("r0_rd0", bus.rd0_data, 32'h0);
    chk("r0_rd1", bus.rd1_data, 32'h0);

    // R3=7, R4=9 on consecutive edges, read on both ports.
    set_wr(1'b1, 5'd3, 32'd7);
    tick();
    set_wr(1'b1, 5'd4, 32'd9);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd3, 5'd4);
    chk("dual_rd0_r3", bus.rd0_data, 32'd7);
    chk("dual_rd1_r4", bus.rd1_data, 32'd9);

    // Same-cycle write/read of R3: no bypass.
    set_wr(1'b1, 5'd3, 32'd11);
    set_rd(5'd3, 5'd4);
    chk("r3_no_bypass", bus.rd0_data, 32'd7);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("r3_after_write", bus.rd0_data, 32'd11);
    chk("r4_untouched", bus.rd1_data, 32'd9);

    // Write disabled leaves R3 alone.
    set_wr(1'b0, 5'd3, 32'h1234);
    tick();
    #1;
    chk("wr_en_low_r3", bus.rd0_data, 32'd11);

    // Back-to-back writes to R7: last one wins.
    set_wr(1'b1, 5'd7, 32'h0000_0001);
    tick();
    set_wr(1'b1, 5'd7, 32'h0000_0002);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd7, 5'd5);
    chk("b2b_r7", bus.rd0_data, 32'h2);
    chk("r5_kept", bus.rd1_data, 32'hDEAD_BEEF);

    // Reset with a concurrent write to R6: write lost, state reinitialised.
    reset = 1'b1;
    set_wr(1'b1, 5'd6, 32'h1);
    tick();
    reset = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd6);
    chk("mid_reset_r5", bus.rd0_data, 32'h0);
    chk("mid_reset_r6", bus.rd1_data, 32'h0);
    set_rd(5'd29, 5'd31);
    chk("mid_reset_sp", bus.rd0_data, SP_VAL);
    chk("mid_reset_ra", bus.rd1_data, 32'h0);
    set_rd(5'd3, 5'd7);
    chk("mid_reset_r3", bus.rd0_data, 32'h0);
    chk("mid_reset_r7", bus.rd1_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
